demux_stream_scheduler: RTL

//  Sequences a 1-to-4 N-bit demux path with valid/ready handshakes: accepts one word per cycle, routes it to one of

---
 rtl/demux_pkg.sv | 24 ++
 rtl/demux_out_slot.sv | 30 +++
 rtl/demux_stream_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, mode encodings, FSM states and round-robin helper
package demux_pkg;

    localparam int NCH = 4;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef enum logic [0:0] {IDLE = ST_IDLE, HOLD = ST_HOLD} state_t;

    // first channel at or after ptr (wrapping) whose bit in avail is set; result is {found, index}
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [NCH-1:0] avail);
        logic [1:0] k;
        rr_pick = 3'b000;
        for (int i = NCH - 1; i >= 0; i--) begin
            k = ptr + i[1:0];
            if (avail[k]) rr_pick = {1'b1, k};
        end
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry output buffer with load/drain/flush, data reads zero while empty
module demux_out_slot #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic [N-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] dout
);

    logic [N-1:0] data;

    // a load wins over a drain so the slot refills in the same cycle it empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= !flush && (load || (valid && !ready));
            if (load) data <= din;
        end
    end

    assign dout = valid ? data : '0;

endmodule

// File: rtl/demux_stream_scheduler.sv
// demux_stream_scheduler: 1-to-4 valid/ready demux with a hold register, per-channel slots and ADDR/RR routing; define DEMUX_SCHED_STATS_EN for per-channel delivery counters
module demux_stream_scheduler
    import demux_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [1:0]       in_dest,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [N-1:0]     y0,
    output logic [N-1:0]     y1,
    output logic [N-1:0]     y2,
    output logic [N-1:0]     y3,
    output logic             busy,
    input  logic [1:0]       stat_sel,
    output logic [CNT_W-1:0] stat_cnt
);

    state_t         state;
    logic [N-1:0]   hold_data;
    logic [1:0]     hold_dest;
    logic           hold_mode;
    logic [1:0]     rr_ptr;
    logic [NCH-1:0] avail;
    logic [NCH-1:0] load;
    logic [2:0]     pick;
    logic [1:0]     target;
    logic           hold_moves;
    logic           in_fire;
    logic [N-1:0]   ydata [NCH];

    // a slot can take the held word if it is empty or is being emptied this cycle
    assign avail      = ~out_valid | out_ready;
    assign pick       = rr_pick(rr_ptr, avail);
    assign target     = hold_mode == MODE_RR ? pick[1:0] : hold_dest;
    assign hold_moves = state == HOLD && !flush && (hold_mode == MODE_RR ? pick[2] : avail[hold_dest]);
    assign in_ready   = rst_n && !flush && (state == IDLE || hold_moves);
    assign in_fire    = in_valid && in_ready;
    assign busy       = state == HOLD || |out_valid;

    // FSM and hold register: capture on input transfer, release when the held word reaches its slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_dest <= '0;
            hold_mode <= MODE_ADDR;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            if (in_fire) begin
                hold_data <= in_data;
                hold_dest <= in_dest;
                hold_mode <= mode;
            end
            state <= in_fire ? HOLD : hold_moves ? IDLE : state;
        end
    end

    // round-robin pointer advances past the channel just served, only for RR words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= 2'd0;
        else if (hold_moves && hold_mode == MODE_RR) rr_ptr <= pick[1:0] + 2'd1;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        assign load[k] = hold_moves && target == 2'(k);
        demux_out_slot #(.N(N)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .load  (load[k]),
            .din   (hold_data),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .dout  (ydata[k])
        );
    end

    assign y0 = ydata[0];
    assign y1 = ydata[1];
    assign y2 = ydata[2];
    assign y3 = ydata[3];

`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt [NCH];

    // delivered-word counters saturate at all-ones and clear only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (out_valid[i] && out_ready[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign stat_cnt = cnt[stat_sel];
`else
    logic unused_stat;
    assign unused_stat = ^stat_sel;
    assign stat_cnt    = '0;
`endif

endmodule
